// File: rtl/jtframe_rom_nslots.sv
// Multi-slot ROM reader: each slot keeps a one-entry 32-bit cache and misses
// are arbitrated (fixed priority or round-robin) onto a single SDRAM read port.
module jtframe_rom_nslots #(
  parameter int SLOTS  = 2,
  parameter int AW     = 22,
  parameter int DW     = 16,
  parameter int RROBIN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [22*SLOTS-1:0]   offset,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [AW*SLOTS-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [DW*SLOTS-1:0]   slot_dout,
  output logic [21:0]           sdram_addr,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read,
  output logic [1:0]            st_dbg
);

  // SDRAM handshake: sdram_req rises together with a stable sdram_addr and
  // holds until the cycle sdram_ack is seen; data_rdy qualifies data_read and
  // may arrive in the same cycle as sdram_ack.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_RDY = 2'd2} state_t;

  state_t               st, st_nxt;
  logic [SLOTS-1:0]     valid, hit, pending;
  logic [AW-1:0]        ctag  [SLOTS];
  logic [31:0]          cdata [SLOTS];
  logic [AW*SLOTS-1:0]  key_flat;
  logic [22*SLOTS-1:0]  raddr_flat;
  logic [1:0]           win, win_sel, last_served;
  logic [AW-1:0]        win_key, sel_key;
  logic [21:0]          sel_addr;
  logic [2:0]           rr_idx;
  logic                 found, stale, issue, fill;

  assign st_dbg = st;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic [AW-1:0] a;
    logic [AW:0]   conv;
    logic [7:0]    byte_sel;
    logic [31:0]   sel;

    assign a    = slot_addr[AW*g +: AW];
    assign key_flat[AW*g +: AW] = (DW == 8) ? {1'b0, a[AW-1:1]} : a;
    assign conv = (DW == 8)  ? {2'b0, a[AW-1:1]} :
                  (DW == 32) ? {a, 1'b0} : {1'b0, a};
    assign raddr_flat[22*g +: 22] = offset[22*g +: 22] + 22'(conv);

    assign hit[g]     = slot_cs[g] & valid[g] & (ctag[g] == key_flat[AW*g +: AW]);
    assign pending[g] = slot_cs[g] & ~hit[g];
    assign slot_ok[g] = rst & hit[g];

    assign byte_sel = a[0] ? cdata[g][15:8] : cdata[g][7:0];
    assign sel      = (DW == 8)  ? {24'b0, byte_sel} :
                      (DW == 16) ? {16'b0, cdata[g][15:0]} : cdata[g];
    assign slot_dout[DW*g +: DW] = rst ? DW'(sel) : '0;
  end

  // Round-robin scans from the slot after the last one served.
  always_comb begin
    win_sel = '0;
    found   = 1'b0;
    rr_idx  = '0;
    if (RROBIN != 0) begin
      for (int k = 1; k <= SLOTS; k++) begin
        rr_idx = {1'b0, last_served} + 3'(k);
        if (rr_idx >= 3'(SLOTS)) rr_idx = rr_idx - 3'(SLOTS);
        for (int j = 0; j < SLOTS; j++) begin
          if (!found && rr_idx == 3'(j) && pending[j]) begin
            win_sel = 2'(j);
            found   = 1'b1;
          end
        end
      end
    end else begin
      for (int j = SLOTS-1; j >= 0; j--) begin
        if (pending[j]) win_sel = 2'(j);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_key  = '0;
    for (int j = 0; j < SLOTS; j++) begin
      if (win_sel == 2'(j)) begin
        sel_addr = raddr_flat[22*j +: 22];
        sel_key  = key_flat[AW*j +: AW];
      end
    end
  end

  always_comb begin
    st_nxt = st;
    issue  = 1'b0;
    fill   = 1'b0;
    case (st)
      IDLE: begin
        if (|pending) begin
          issue  = 1'b1;
          st_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          if (data_rdy) begin
            fill   = 1'b1;
            st_nxt = IDLE;
          end else begin
            st_nxt = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (data_rdy) begin
          fill   = 1'b1;
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= IDLE;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      valid       <= '0;
      stale       <= 1'b0;
      last_served <= 2'(SLOTS-1);
      win         <= '0;
      win_key     <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        ctag[i]  <= '0;
        cdata[i] <= '0;
      end
    end else begin
      st <= st_nxt;
      if (issue) begin
        sdram_req   <= 1'b1;
        sdram_addr  <= sel_addr;
        win         <= win_sel;
        win_key     <= sel_key;
        last_served <= win_sel;
      end else if (st == WAIT_ACK && sdram_ack) begin
        sdram_req <= 1'b0;
      end
      for (int i = 0; i < SLOTS; i++) begin
        if (fill && win == 2'(i)) begin
          ctag[i]  <= win_key;
          cdata[i] <= data_read;
        end
      end
      // A clr seen mid-transaction poisons the fill so old ROM data never becomes valid.
      if (clr) begin
        valid <= '0;
      end else if (fill && !stale) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (win == 2'(i)) valid[i] <= 1'b1;
        end
      end
      if (fill) stale <= 1'b0;
      else if (clr && st != IDLE) stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_rom_nslots.sv
// Directed bench: a 3-slot 16-bit round-robin instance and a 2-slot 8-bit
// fixed-priority instance share the clock, reset, clr and SDRAM response lines.
module tb_jtframe_rom_nslots;

  logic        clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic        sdram_ack = 1'b0, data_rdy = 1'b0;
  logic [31:0] data_read = '0;

  logic [65:0] offset_a = '0, addr_a = '0;
  logic [2:0]  cs_a = '0, ok_a;
  logic [47:0] dout_a;
  logic [21:0] sdaddr_a;
  logic        req_a;
  logic [1:0]  st_a;

  logic [43:0] offset_b = '0, addr_b = '0;
  logic [1:0]  cs_b = '0, ok_b;
  logic [15:0] dout_b;
  logic [21:0] sdaddr_b;
  logic        req_b;
  logic [1:0]  st_b;

  int checks = 0, errors = 0;
  logic [21:0] seen;
  logic [21:0] rr_exp [4] = '{22'h000010, 22'h001020, 22'h002030, 22'h000011};
  int          rr_slot [4] = '{0, 1, 2, 0};

  always #5 clk = ~clk;

  jtframe_rom_nslots #(.SLOTS(3), .AW(22), .DW(16), .RROBIN(1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset_a), .slot_cs(cs_a),
    .slot_addr(addr_a), .slot_ok(ok_a), .slot_dout(dout_a), .sdram_addr(sdaddr_a),
    .sdram_req(req_a), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read), .st_dbg(st_a)
  );

  jtframe_rom_nslots #(.SLOTS(2), .AW(22), .DW(8), .RROBIN(0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset_b), .slot_cs(cs_b),
    .slot_addr(addr_b), .slot_ok(ok_b), .slot_dout(dout_b), .sdram_addr(sdaddr_b),
    .sdram_req(req_b), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read), .st_dbg(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input bit use_b);
    int n = 0;
    while ((use_b ? req_b : req_a) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_up", 32'(use_b ? req_b : req_a), 32'd1);
  endtask

  task automatic serve(input bit use_b, input logic [31:0] d, output logic [21:0] got_addr);
    wait_req(use_b);
    got_addr  = use_b ? sdaddr_b : sdaddr_a;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_read = d;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
  endtask

  initial begin
    // Reset state, with requests held high so output gating is exercised
    tick(); tick();
    cs_a = 3'b111;
    #1;
    check("rst_ok",   32'(ok_a), 32'd0);
    check("rst_dout", dout_a[31:0], 32'd0);
    check("rst_req",  32'(req_a), 32'd0);
    check("rst_addr", 32'(sdaddr_a), 32'd0);
    check("rst_st",   32'(st_a), 32'd0);
    cs_a = '0;
    rst  = 1'b1;
    tick();

    // 16-bit miss then hit
    offset_a[21:0] = 22'h100000;
    addr_a[21:0]   = 22'h100;
    cs_a           = 3'b001;
    tick();
    check("w16_req",      32'(req_a), 32'd1);
    check("w16_addr",     32'(sdaddr_a), 32'h100100);
    check("w16_miss_ok",  32'(ok_a), 32'd0);
    tick();
    check("w16_req_hold", 32'(req_a), 32'd1);
    check("w16_addr_hold",32'(sdaddr_a), 32'h100100);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("w16_req_drop", 32'(req_a), 32'd0);
    check("w16_st_rdy",   32'(st_a), 32'd2);
    tick(); tick();
    data_read = 32'h0000_BEEF;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    check("w16_ok",   32'(ok_a), 32'd1);
    check("w16_dout", 32'(dout_a[15:0]), 32'hBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w16_hit_noreq", 32'(req_a), 32'd0);
    end
    check("w16_hit_ok", 32'(ok_a), 32'd1);
    cs_a = '0;

    // Round-robin order with all three slots missing continuously
    rst = 1'b0;
    tick();
    rst      = 1'b1;
    offset_a = {22'h2000, 22'h1000, 22'h0};
    addr_a   = {22'h30, 22'h20, 22'h10};
    cs_a     = 3'b111;
    for (int n = 0; n < 4; n++) begin
      serve(1'b0, 32'h1000 + n, seen);
      check("rr_order", 32'(seen), 32'(rr_exp[n]));
      addr_a[22*rr_slot[n] +: 22] = addr_a[22*rr_slot[n] +: 22] + 22'd1;
    end
    cs_a = '0;

    // Fixed priority and 8-bit byte select
    offset_b = {22'h0, 22'h3000};
    addr_b   = {22'h201, 22'h10};
    cs_b     = 2'b11;
    serve(1'b1, 32'h0000_0011, seen);
    check("fp_first",  32'(seen), 32'h3008);
    addr_b[21:0] = 22'h14;
    serve(1'b1, 32'h0000_0022, seen);
    check("fp_again",  32'(seen), 32'h300A);
    check("fp_ok",     32'(ok_b), 32'd1);
    check("b8_lo_dout",32'(dout_b[7:0]), 32'h22);
    cs_b = 2'b10;
    serve(1'b1, 32'h0000_A55A, seen);
    check("b8_addr",    32'(seen), 32'h100);
    check("b8_ok_odd",  32'(ok_b), 32'd2);
    check("b8_dout_odd",32'(dout_b[15:8]), 32'hA5);
    addr_b[43:22] = 22'h200;
    #1;
    check("b8_ok_even",  32'(ok_b), 32'd2);
    check("b8_dout_even",32'(dout_b[15:8]), 32'h5A);
    cs_b = '0;

    // clr while waiting for data leaves the slot invalid and it re-requests
    rst = 1'b0;
    tick();
    rst             = 1'b1;
    offset_a[43:22] = 22'h0;
    addr_a[43:22]   = 22'h40;
    cs_a            = 3'b010;
    wait_req(1'b0);
    check("clr_addr", 32'(sdaddr_a), 32'h40);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_st_rdy", 32'(st_a), 32'd2);
    data_read = 32'h0000_5555;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    check("clr_st_idle", 32'(st_a), 32'd0);
    check("clr_ok",      32'(ok_a), 32'd0);
    tick();
    check("clr_rereq",      32'(req_a), 32'd1);
    check("clr_rereq_addr", 32'(sdaddr_a), 32'h40);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_read = 32'h0000_1234;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    check("clr_refill_ok",   32'(ok_a), 32'd2);
    check("clr_refill_dout", 32'(dout_a[31:16]), 32'h1234);

    // ack and data_rdy in the same cycle
    offset_a[65:44] = 22'h2000;
    addr_a[65:44]   = 22'h50;
    cs_a            = 3'b100;
    wait_req(1'b0);
    check("same_addr", 32'(sdaddr_a), 32'h2050);
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'h0000_CAFE;
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    check("same_st",   32'(st_a), 32'd0);
    check("same_req",  32'(req_a), 32'd0);
    check("same_ok",   32'(ok_a), 32'd4);
    check("same_dout", 32'(dout_a[47:32]), 32'hCAFE);
    tick();
    check("same_noreq", 32'(req_a), 32'd0);

    // Reset during WAIT_ACK, with another slot hitting meanwhile
    offset_a[21:0] = 22'h0;
    addr_a[21:0]   = 22'h60;
    cs_a           = 3'b101;
    wait_req(1'b0);
    check("rwa_addr",  32'(sdaddr_a), 32'h60);
    check("rwa_hit2",  32'(ok_a), 32'd4);
    rst = 1'b0;
    #1;
    check("rwa_gate_ok",   32'(ok_a), 32'd0);
    check("rwa_gate_dout", 32'(dout_a[47:32]), 32'd0);
    tick();
    check("rwa_req",  32'(req_a), 32'd0);
    check("rwa_sda",  32'(sdaddr_a), 32'd0);
    check("rwa_st",   32'(st_a), 32'd0);
    rst = 1'b1;
    tick();
    check("rwa_fresh_req",  32'(req_a), 32'd1);
    check("rwa_fresh_addr", 32'(sdaddr_a), 32'h60);
    cs_a = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtframe_rom_nslots.md
JTFRAME_ROM_NSLOTS -- requirements
Module: jtframe_rom_nslots

Interface
REQ-001 Parameter SLOTS, default 2: number of requesting slots, legal range 1..4.
REQ-002 Parameter AW, default 22: slot address width, common to all slots.
REQ-003 Parameter DW, default 16: slot data width, legal values 8, 16 or 32, common to all slots.
REQ-004 Parameter RROBIN, default 0: 0 selects fixed priority (lowest slot index wins), 1 selects round-robin.
REQ-005 clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 clr  in  1  invalidates all slot caches.
REQ-008 offset  in  22*SLOTS  per-slot SDRAM word offset; slot i is at bits [22*i+21:22*i].
REQ-009 slot_cs  in  SLOTS  per-slot request.
REQ-010 slot_addr  in  AW*SLOTS  packed slot addresses, in byte units for DW=8 and word units otherwise.
REQ-011 slot_ok  out  SLOTS  per-slot data valid.
REQ-012 slot_dout  out  DW*SLOTS  packed slot data.
REQ-013 sdram_addr  out  22  SDRAM word address.
REQ-014 sdram_req  out  1  read request.
REQ-015 sdram_ack  in  1  request accepted.
REQ-016 data_rdy  in  1  data_read valid.
REQ-017 data_read  in  32  SDRAM read data.

Function
REQ-018 Each slot SHALL hold a one-entry cache with fields valid, tag (AW bits) and data (32 bits).
REQ-019 Tag compare key: slot_addr[AW-1:1] for DW=8; full slot_addr otherwise.
REQ-020 slot_ok[i] SHALL be combinational: slot_cs[i] & valid[i] & (tag[i]==key[i]). A hit therefore has zero latency and drives no SDRAM traffic.
REQ-021 Slot i is pending when slot_cs[i] is high and slot_ok[i] is low.
REQ-022 Data select for DW=8: cache data[15:8] when slot_addr[0]=1, else data[7:0]. For DW=16: data[15:0]. For DW=32: data[31:0].
REQ-023 SDRAM address SHALL be offset_i plus the converted address, truncated to 22 bits:
- DW=8: addr>>1
- DW=16: addr
- DW=32: {addr,1'b0}
REQ-024 The FSM SHALL have three states: IDLE, WAIT_ACK and WAIT_RDY.
REQ-025 In IDLE with any slot pending, the FSM SHALL:
- select the winner per RROBIN;
- latch the winner's index and key;
- register sdram_addr and assert sdram_req;
- move to WAIT_ACK on the next cycle.
REQ-026 Round-robin search SHALL start at (last_served+1) mod SLOTS. last_served resets to SLOTS-1.
REQ-027 In WAIT_ACK, sdram_req SHALL stay high and sdram_addr stable until sdram_ack. On sdram_ack, sdram_req SHALL drop the next cycle and the FSM SHALL go to WAIT_RDY.
REQ-028 If sdram_ack and data_rdy are high in the same WAIT_ACK cycle, it SHALL be treated as ack followed by completion, and the FSM SHALL return to IDLE.
REQ-029 Completion on data_rdy in WAIT_RDY SHALL write the winner's cache (data=data_read, tag=latched key, valid=1), then return to IDLE. The earliest next request is the following cycle.
REQ-030 A slot address change or cs deassertion during a transaction SHALL NOT abort it. The cache is filled with the latched key, and a new miss is re-requested from IDLE.
REQ-031 clr SHALL clear every valid bit on that cycle.
REQ-032 A clr asserted while a transaction is outstanding SHALL mark it stale; its completion SHALL NOT set valid. The stale flag clears on return to IDLE.
REQ-033 Only one SDRAM transaction SHALL be outstanding at any time.
REQ-034 Non-winning slots SHALL retain their cache contents, and their hits SHALL be served during a transaction.

Reset
REQ-035 On rst low at a clock edge, the block SHALL, regardless of state mid-transaction:
- enter IDLE;
- set sdram_req=0 and sdram_addr=0;
- clear all valid, tag and data to 0, and the stale flag;
- set last_served=SLOTS-1.
REQ-036 While in reset, all slot_ok SHALL be 0 and all slot_dout SHALL be 0.

Verification
REQ-037 Stimulus: DW=16, slot0 cs with addr 0x100, offset0=0x10_0000; ack at +2, rdy with 0x0000_BEEF at +5. Response: sdram_addr=0x10_0100, then slot_ok[0]=1 and dout=0xBEEF; a repeat of addr 0x100 hits with no further sdram_req.
REQ-038 Stimulus: RROBIN=1, SLOTS=3, all three slots missing continuously. Response: service order is 0,1,2,0. With RROBIN=0, slot0 wins every time it is pending.
REQ-039 Stimulus: DW=8, slot1 addr 0x201, data_read=0x0000_A55A, offset1=0. Response: sdram_addr=0x100 and dout=0xA5; switching to addr 0x200 hits with dout=0x5A.
REQ-040 Stimulus: clr pulsed in WAIT_RDY. Response: completion returns to IDLE with valid=0 and slot_ok low; the slot re-requests.
REQ-041 Stimulus: sdram_ack and data_rdy in the same cycle. Response: the cache is filled and the FSM is back in IDLE one cycle later.
REQ-042 Stimulus: rst low during WAIT_ACK. Response: sdram_req=0 on the next edge, all slot_ok=0, and after release a pending slot issues a fresh request.
